// File: rtl/rv32i_gcd_ctrl.sv
// rtl/rv32i_gcd_ctrl.sv - host-side GCD request sequencer
// Starts the core on a host request, snoops the x10 result write and returns it.
module rv32i_gcd_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int          CNT_W          = 16,
   parameter logic [4:0]  RESULT_REG     = 5'd10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   output logic             calc_start,
   output logic [31:0]      gcd_a,
   output logic [31:0]      gcd_b,
   input  logic             wb_we,
   input  logic [4:0]       wb_addr,
   input  logic [31:0]      wb_data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_result,
   output logic             resp_timeout,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0] state;
   logic       capture;

   // x0 is hard-wired in the core, so a write to it never completes a run
   assign capture = wb_we && (wb_addr == RESULT_REG) && (wb_addr != 5'd0);

   assign req_ready  = (state == IDLE);
   assign calc_start = (state == RUN);
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         gcd_a        <= '0;
         gcd_b        <= '0;
         cycle_count  <= '0;
         resp_result  <= '0;
         resp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  gcd_a       <= req_a;
                  gcd_b       <= req_b;
                  cycle_count <= '0;
                  if ((req_a == 32'd0) || (req_b == 32'd0)) begin
                     resp_result  <= req_a | req_b;
                     resp_timeout <= 1'b0;
                     state        <= RESP;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               // the counter freezes on the exit cycle so it reports the last RUN index
               if (capture) begin
                  resp_result  <= wb_data;
                  resp_timeout <= 1'b0;
                  state        <= RESP;
               end else if (cycle_count == LAST_CNT) begin
                  resp_result  <= 32'd0;
                  resp_timeout <= 1'b1;
                  state        <= RESP;
               end else begin
                  cycle_count <= cycle_count + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
